// File: rtl/loopback_rx_pkt_monitor_if.sv
// Receive-side bus between the loopback RX FIFO tap and the packet monitor.
//   link_up, rx_valid, rx_eof, rx_overrun, ctrl_clr : stream/control into the monitor
//   status_out[31:0], pkt_good                      : status word and good-packet pulse out
interface loopback_rx_pkt_monitor_if;
    logic        link_up;
    logic        rx_valid;
    logic        rx_eof;
    logic        rx_overrun;
    logic        ctrl_clr;
    logic [31:0] status_out;
    logic        pkt_good;

    modport master (
        output link_up, rx_valid, rx_eof, rx_overrun, ctrl_clr,
        input  status_out, pkt_good
    );

    modport slave (
        input  link_up, rx_valid, rx_eof, rx_overrun, ctrl_clr,
        output status_out, pkt_good
    );
endinterface

// File: rtl/loopback_rx_pkt_monitor.sv
// Loopback RX packet monitor: delimits packets on the FIFO input stream, checks
// length against EXP_LEN, counts good packets, length errors and FIFO overruns,
// and publishes a registered 32-bit status word for the PPC software register.
//   user_clk, user_rst : clock, asynchronous active-high reset
//   bus (slave)        : link_up/rx_valid/rx_eof/rx_overrun/ctrl_clr in,
//                        status_out/pkt_good out
// status_out = {pkt_cnt[15:0], err_cnt[7:0], ovr_cnt[3:0], in_pkt, sticky_ovr,
//               sticky_len, link_up}
module loopback_rx_pkt_monitor #(
    parameter int unsigned EXP_LEN = 64,
    parameter int unsigned LEN_W   = 16
) (
    input  logic                      user_clk,
    input  logic                      user_rst,
    loopback_rx_pkt_monitor_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RX   = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] EXP_LEN_W = LEN_W'(EXP_LEN);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] wcnt_q, wcnt_d, wcnt_inc;
    logic [15:0]      pkt_cnt_q;
    logic [7:0]       err_cnt_q;
    logic [3:0]       ovr_cnt_q;
    logic             sticky_ovr_q;
    logic             sticky_len_q;
    logic             link_q;
    logic             pkt_good_q;

    logic             word_c;
    logic             good_c;
    logic             len_err_c;
    logic             abort_err_c;

    assign word_c   = bus.rx_valid & bus.link_up;
    assign wcnt_inc = wcnt_q + LEN_W'(1);

    // State register
    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Next state and per-cycle packet events.
    // Link loss dominates overrun, which dominates normal word handling, so an
    // abandoned packet is counted exactly once and never as good.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        good_c      = 1'b0;
        len_err_c   = 1'b0;
        abort_err_c = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (word_c) begin
                    if (bus.rx_eof) begin
                        if (EXP_LEN_W == LEN_W'(1)) good_c    = 1'b1;
                        else                        len_err_c = 1'b1;
                    end else begin
                        wcnt_d  = LEN_W'(1);
                        state_d = ST_RX;
                    end
                end
            end
            ST_RX: begin
                if (!bus.link_up) begin
                    abort_err_c = 1'b1;
                    state_d     = ST_IDLE;
                end else if (bus.rx_overrun) begin
                    abort_err_c = 1'b1;
                    state_d     = (word_c && bus.rx_eof) ? ST_IDLE : ST_DROP;
                end else if (word_c) begin
                    if (bus.rx_eof) begin
                        if (wcnt_inc == EXP_LEN_W) good_c    = 1'b1;
                        else                       len_err_c = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        wcnt_d = wcnt_inc;
                        // Reaching EXP_LEN without eof means the packet is too long
                        if (wcnt_inc >= EXP_LEN_W) begin
                            len_err_c = 1'b1;
                            state_d   = ST_DROP;
                        end
                    end
                end
            end
            ST_DROP: begin
                if (!bus.link_up || (word_c && bus.rx_eof)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Counters and sticky bits; clear wins over any same-cycle increment
    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            pkt_cnt_q    <= '0;
            err_cnt_q    <= '0;
            ovr_cnt_q    <= '0;
            sticky_ovr_q <= 1'b0;
            sticky_len_q <= 1'b0;
            link_q       <= 1'b0;
            pkt_good_q   <= 1'b0;
        end else begin
            link_q     <= bus.link_up;
            pkt_good_q <= good_c;
            if (bus.ctrl_clr) begin
                pkt_cnt_q    <= '0;
                err_cnt_q    <= '0;
                ovr_cnt_q    <= '0;
                sticky_ovr_q <= 1'b0;
                sticky_len_q <= 1'b0;
            end else begin
                if (good_c) pkt_cnt_q <= pkt_cnt_q + 16'd1;
                if ((len_err_c || abort_err_c) && (err_cnt_q != 8'hFF))
                    err_cnt_q <= err_cnt_q + 8'd1;
                if (bus.rx_overrun) begin
                    sticky_ovr_q <= 1'b1;
                    if (ovr_cnt_q != 4'hF) ovr_cnt_q <= ovr_cnt_q + 4'd1;
                end
                if (len_err_c) sticky_len_q <= 1'b1;
            end
        end
    end

    assign bus.status_out = {pkt_cnt_q, err_cnt_q, ovr_cnt_q, (state_q != ST_IDLE),
                             sticky_ovr_q, sticky_len_q, link_q};
    assign bus.pkt_good   = pkt_good_q;

endmodule

// File: tb/tb_loopback_rx_pkt_monitor.sv
// Bench for loopback_rx_pkt_monitor: directed scenarios plus randomized packets
// checked against a packet-level expectation model.
module tb_loopback_rx_pkt_monitor;

    localparam int unsigned EXP = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    loopback_rx_pkt_monitor_if bus ();
    loopback_rx_pkt_monitor_if bus1 ();

    loopback_rx_pkt_monitor #(.EXP_LEN(EXP), .LEN_W(16)) dut (
        .user_clk (clk),
        .user_rst (rst),
        .bus      (bus)
    );

    // Single-word packets make the 16-bit wrap reachable in a short run
    loopback_rx_pkt_monitor #(.EXP_LEN(1), .LEN_W(16)) dut1 (
        .user_clk (clk),
        .user_rst (rst),
        .bus      (bus1)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int good_seen  = 0;
    int good1_seen = 0;

    // Expectation model, packet level
    int m_pkt, m_err, m_ovr, m_goods;
    bit m_sovr, m_slen, m_link;

    function automatic logic [31:0] exp_status(input bit in_pkt);
        return {16'(m_pkt), 8'(m_err), 4'(m_ovr), in_pkt, m_sovr, m_slen, m_link};
    endfunction

    function automatic void m_clear();
        m_pkt = 0; m_err = 0; m_ovr = 0; m_sovr = 0; m_slen = 0;
    endfunction

    function automatic void m_inc_err();
        if (m_err < 255) m_err++;
    endfunction

    function automatic void m_inc_ovr();
        if (m_ovr < 15) m_ovr++;
        m_sovr = 1;
    endfunction

    // Advance one clock; outputs are observed 1 time unit after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
        if (bus.pkt_good === 1'b1)  good_seen++;
        if (bus1.pkt_good === 1'b1) good1_seen++;
    endtask

    task automatic idle_inputs();
        bus.rx_valid = 0; bus.rx_eof = 0; bus.rx_overrun = 0; bus.ctrl_clr = 0;
    endtask

    task automatic clear_all();
        bus.ctrl_clr = 1;
        cyc();
        bus.ctrl_clr = 0;
        m_clear();
    endtask

    // Send one packet; ovr_at (1-based word index, 0 = none) pulses rx_overrun
    // with that word, clr_last raises ctrl_clr with the final word.
    task automatic send_pkt(input int len, input int ovr_at, input bit gaps, input bit clr_last);
        bit abort;
        for (int w = 1; w <= len; w++) begin
            if (gaps) begin
                int n;
                n = $urandom_range(0, 2);
                repeat (n) begin
                    idle_inputs();
                    cyc();
                end
            end
            bus.rx_valid   = 1;
            bus.rx_eof     = (w == len);
            bus.rx_overrun = (w == ovr_at);
            bus.ctrl_clr   = clr_last && (w == len);
            cyc();
        end
        idle_inputs();
        // An overrun while the packet is mid-stream (words 2..EXP) abandons it
        abort = (ovr_at >= 2) && (ovr_at <= EXP);
        if (ovr_at != 0) m_inc_ovr();
        if (abort) m_inc_err();
        else if (len != EXP) begin
            m_inc_err();
            m_slen = 1;
        end else begin
            m_pkt++;
            m_goods++;
        end
        if (clr_last) m_clear();
    endtask

    task automatic test_reset();
        rst = 1;
        bus.link_up = 1;
        idle_inputs();
        bus1.link_up = 0; bus1.rx_valid = 0; bus1.rx_eof = 0;
        bus1.rx_overrun = 0; bus1.ctrl_clr = 0;
        #1;
        n_checks++;
        if (bus.status_out !== 32'h0) $display("FAIL reset_status: got %h want %h", bus.status_out, 32'h0);
        else n_pass++;
        n_checks++;
        if (bus.pkt_good !== 1'b0) $display("FAIL reset_pkt_good: got %b want 0", bus.pkt_good);
        else n_pass++;
        cyc();
        cyc();
        rst = 0;
        cyc();
        m_clear();
        m_link = 1;
        m_goods = 0;
        good_seen = 0;
        n_checks++;
        if (bus.status_out !== 32'h0000_0001) $display("FAIL after_reset_link: got %h want %h", bus.status_out, 32'h0000_0001);
        else n_pass++;
    endtask

    task automatic test_good();
        int g0;
        g0 = good_seen;
        repeat (3) send_pkt(EXP, 0, 0, 0);
        cyc();
        n_checks++;
        if (bus.status_out !== 32'h0003_0001) $display("FAIL good_status: got %h want %h", bus.status_out, 32'h0003_0001);
        else n_pass++;
        n_checks++;
        if (good_seen - g0 !== 3) $display("FAIL good_pulses: got %0d want 3", good_seen - g0);
        else n_pass++;
    endtask

    task automatic test_length();
        clear_all();
        send_pkt(10, 0, 0, 0);
        n_checks++;
        if (bus.status_out !== 32'h0000_0103) $display("FAIL short_pkt: got %h want %h", bus.status_out, 32'h0000_0103);
        else n_pass++;
        for (int w = 1; w <= 70; w++) begin
            bus.rx_valid = 1;
            bus.rx_eof   = (w == 70);
            cyc();
            if (w == 63) begin
                n_checks++;
                if (bus.status_out[15:8] !== 8'd1) $display("FAIL long_w63_err: got %0d want 1", bus.status_out[15:8]);
                else n_pass++;
            end
            if (w == 64) begin
                n_checks++;
                if (bus.status_out[15:8] !== 8'd2 || bus.status_out[3] !== 1'b1)
                    $display("FAIL long_w64_drop: got err %0d in_pkt %b want 2 1", bus.status_out[15:8], bus.status_out[3]);
                else n_pass++;
            end
        end
        idle_inputs();
        m_inc_err();
        m_slen = 1;
        n_checks++;
        if (bus.status_out !== 32'h0000_0203) $display("FAIL long_pkt_end: got %h want %h", bus.status_out, 32'h0000_0203);
        else n_pass++;
    endtask

    task automatic test_overrun();
        int g0;
        clear_all();
        g0 = good_seen;
        send_pkt(EXP, 20, 0, 0);
        n_checks++;
        if (bus.status_out !== 32'h0000_0115) $display("FAIL ovr_pkt: got %h want %h", bus.status_out, 32'h0000_0115);
        else n_pass++;
        send_pkt(EXP, 0, 0, 0);
        n_checks++;
        if (bus.status_out !== 32'h0001_0115) $display("FAIL ovr_then_good: got %h want %h", bus.status_out, 32'h0001_0115);
        else n_pass++;
        n_checks++;
        if (good_seen - g0 !== 1) $display("FAIL ovr_pulses: got %0d want 1", good_seen - g0);
        else n_pass++;
    endtask

    task automatic test_saturation();
        clear_all();
        repeat (300) send_pkt(1, 0, 0, 0);
        n_checks++;
        if (bus.status_out[15:8] !== 8'd255) $display("FAIL err_sat: got %0d want 255", bus.status_out[15:8]);
        else n_pass++;
        repeat (20) begin
            bus.rx_overrun = 1;
            cyc();
            m_inc_ovr();
        end
        idle_inputs();
        n_checks++;
        if (bus.status_out[7:4] !== 4'd15) $display("FAIL ovr_sat: got %0d want 15", bus.status_out[7:4]);
        else n_pass++;
        n_checks++;
        if (bus.status_out !== exp_status(0)) $display("FAIL sat_status: got %h want %h", bus.status_out, exp_status(0));
        else n_pass++;
    endtask

    task automatic test_clear_vs_event();
        int g0;
        clear_all();
        g0 = good_seen;
        send_pkt(EXP, 0, 0, 1);
        n_checks++;
        if (bus.status_out !== 32'h0000_0001) $display("FAIL clr_vs_eof: got %h want %h", bus.status_out, 32'h0000_0001);
        else n_pass++;
        n_checks++;
        if (good_seen - g0 !== 1) $display("FAIL clr_pulse: got %0d want 1", good_seen - g0);
        else n_pass++;
        send_pkt(EXP, 0, 0, 0);
        n_checks++;
        if (bus.status_out !== 32'h0001_0001) $display("FAIL clr_next_good: got %h want %h", bus.status_out, 32'h0001_0001);
        else n_pass++;
    endtask

    task automatic test_link_drop();
        clear_all();
        for (int w = 1; w <= 29; w++) begin
            bus.rx_valid = 1;
            cyc();
        end
        idle_inputs();
        n_checks++;
        if (bus.status_out[3] !== 1'b1) $display("FAIL link_in_pkt: got %b want 1", bus.status_out[3]);
        else n_pass++;
        bus.link_up = 0;
        cyc();
        m_inc_err();
        m_link = 0;
        n_checks++;
        if (bus.status_out !== 32'h0000_0100) $display("FAIL link_drop: got %h want %h", bus.status_out, 32'h0000_0100);
        else n_pass++;
        bus.link_up = 1;
        cyc();
        m_link = 1;
        send_pkt(EXP, 0, 0, 0);
        n_checks++;
        if (bus.status_out !== 32'h0001_0101) $display("FAIL link_recover: got %h want %h", bus.status_out, 32'h0001_0101);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        for (int w = 1; w <= 15; w++) begin
            bus.rx_valid = 1;
            cyc();
        end
        idle_inputs();
        rst = 1;
        #1;
        n_checks++;
        if (bus.status_out !== 32'h0) $display("FAIL rst_mid_async: got %h want %h", bus.status_out, 32'h0);
        else n_pass++;
        #2;
        rst = 0;
        m_clear();
        send_pkt(EXP, 0, 0, 0);
        n_checks++;
        if (bus.status_out !== 32'h0001_0001) $display("FAIL rst_mid_next: got %h want %h", bus.status_out, 32'h0001_0001);
        else n_pass++;
    endtask

    task automatic test_random();
        int g0, len, ovr_at;
        bit gaps, clr;
        clear_all();
        g0 = good_seen;
        m_goods = 0;
        for (int i = 0; i < 40; i++) begin
            len    = ($urandom_range(0, 1) == 1) ? EXP : $urandom_range(1, 80);
            ovr_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len) : 0;
            gaps   = 1'($urandom_range(0, 1));
            clr    = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 4) == 0) begin
                bus.rx_overrun = 1;
                cyc();
                bus.rx_overrun = 0;
                m_inc_ovr();
            end
            send_pkt(len, ovr_at, gaps, clr);
            n_checks++;
            if (bus.status_out !== exp_status(0))
                $display("FAIL rand_pkt%0d len %0d ovr %0d: got %h want %h", i, len, ovr_at, bus.status_out, exp_status(0));
            else n_pass++;
        end
        n_checks++;
        if (good_seen - g0 !== m_goods) $display("FAIL rand_pulses: got %0d want %0d", good_seen - g0, m_goods);
        else n_pass++;
    endtask

    task automatic test_wrap();
        bus1.link_up  = 1;
        bus1.rx_valid = 1;
        bus1.rx_eof   = 1;
        good1_seen = 0;
        repeat (65535) cyc();
        n_checks++;
        if (bus1.status_out[31:16] !== 16'hFFFF) $display("FAIL wrap_max: got %h want ffff", bus1.status_out[31:16]);
        else n_pass++;
        cyc();
        bus1.rx_valid = 0;
        bus1.rx_eof   = 0;
        n_checks++;
        if (bus1.status_out !== 32'h0000_0001) $display("FAIL wrap_zero: got %h want %h", bus1.status_out, 32'h0000_0001);
        else n_pass++;
        n_checks++;
        if (good1_seen !== 65536) $display("FAIL wrap_pulses: got %0d want 65536", good1_seen);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_good();
        test_length();
        test_overrun();
        test_saturation();
        test_clear_vs_event();
        test_link_drop();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
